// File: rtl/bcd_conv_sched.sv
// Shared double-dabble binary-to-BCD engine, one bit per clock, time-shared between two
// requesters through a round-robin arbiter with start/ack/done handshake.
module bcd_conv_sched #(
   parameter int unsigned WIDTH  = 7,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic [WIDTH-1:0]      bin0,
   input  logic                  req1,
   input  logic [WIDTH-1:0]      bin1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  busy,
   output logic                  done,
   output logic                  done_id,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned BcdW = 4 * DIGITS;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic [BcdW-1:0]   scr_q, scr_d, scr_adj;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic              last_q, last_d;
   logic              id_q, id_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              done_id_q, done_id_d;
   logic              grant_v, grant_id;

   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign bcd_out = bcd_q;

   // Round-robin: on a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant_v  = req0 | req1;
      grant_id = (req0 && req1) ? ~last_q : req1;
   end

   // Add-3 correction on every digit, no carry between digits.
   always_comb begin
      scr_adj = '0;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (scr_q[4*d +: 4] >= 4'd5) begin
            scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
         end else begin
            scr_adj[4*d +: 4] = scr_q[4*d +: 4];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         opnd_q    <= '0;
         scr_q     <= '0;
         bcd_q     <= '0;
         last_q    <= 1'b1;
         id_q      <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opnd_q    <= opnd_d;
         scr_q     <= scr_d;
         bcd_q     <= bcd_d;
         last_q    <= last_d;
         id_q      <= id_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant_v) state_d = StShift;
         StShift: if (cnt_q == CntLast) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      opnd_d    = opnd_q;
      scr_d     = scr_q;
      bcd_d     = bcd_q;
      last_d    = last_q;
      id_d      = id_q;
      done_id_d = done_id_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      done_d    = 1'b0;
      busy_d    = (state_d != StIdle);
      unique case (state_q)
         StIdle: begin
            if (grant_v) begin
               opnd_d = grant_id ? bin1 : bin0;
               scr_d  = '0;
               cnt_d  = '0;
               id_d   = grant_id;
               last_d = grant_id;
               ack0_d = ~grant_id;
               ack1_d = grant_id;
            end
         end
         StShift: begin
            {scr_d, opnd_d} = {scr_adj, opnd_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               bcd_d     = scr_d;
               done_id_d = id_q;
               done_d    = 1'b1;
            end
         end
         StDone: begin
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: single conversions, arbitration, fairness,
// mid-operation reset and a full 0..127 sweep against a decimal model.
module tb_bcd_conv_sched;

   logic        clk;
   logic        rst;
   logic        req0, req1;
   logic [6:0]  bin0, bin1;
   logic        ack0, ack1, busy, done, done_id;
   logic [11:0] bcd_out;

   int checks = 0;
   int errors = 0;

   bcd_conv_sched #(
      .WIDTH  (7),
      .DIGITS (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req0    (req0),
      .bin0    (bin0),
      .req1    (req1),
      .bin1    (bin1),
      .ack0    (ack0),
      .ack1    (ack1),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .bcd_out (bcd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to the next cycle and settle past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Request in the current (idle) cycle t, drop on ack, check full timing; ends in t+9.
   task automatic conv(input logic id, input logic [6:0] val, input logic [11:0] exp_bcd);
      if (id) begin
         req1 = 1'b1;
         bin1 = val;
      end else begin
         req0 = 1'b1;
         bin0 = val;
      end
      tick();
      chk("ack", {ack1, ack0}, id ? 2'b10 : 2'b01);
      chk("busy_on", busy, 1'b1);
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      chk("ack_drop", {ack1, ack0}, 2'b00);
      repeat (5) tick();
      chk("done_early", done, 1'b0);
      tick();
      chk("done", done, 1'b1);
      chk("bcd", bcd_out, exp_bcd);
      chk("done_id", done_id, id);
      tick();
      chk("idle", {busy, done}, 2'b00);
      chk("bcd_hold", bcd_out, exp_bcd);
   endtask

   initial begin
      logic [11:0] gold;
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      bin0 = '0;
      bin1 = '0;

      // Reset then idle
      do_reset();
      for (int i = 0; i < 20; i++) begin
         chk("reset_idle", {ack0, ack1, busy, done, done_id, bcd_out}, 17'h0);
         tick();
      end

      // Single conversions on requester 0
      conv(1'b0, 7'd0,   12'h000);
      conv(1'b0, 7'd99,  12'h099);
      conv(1'b0, 7'd127, 12'h127);

      // Simultaneous requests: requester 0 wins the first tie
      do_reset();
      req0 = 1'b1; bin0 = 7'd45;
      req1 = 1'b1; bin1 = 7'd88;
      tick();                                    // t+1
      chk("sim_ack0", {ack1, ack0}, 2'b01);
      req0 = 1'b0;
      repeat (7) tick();                         // t+8
      chk("sim_done0", done, 1'b1);
      chk("sim_bcd0", bcd_out, 12'h045);
      chk("sim_id0", done_id, 1'b0);
      tick();                                    // t+9
      chk("sim_ack_gap", {ack1, ack0, busy}, 3'b000);
      tick();                                    // t+10
      chk("sim_ack1", {ack1, ack0}, 2'b10);
      req1 = 1'b0;
      repeat (7) tick();                         // t+17
      chk("sim_done1", done, 1'b1);
      chk("sim_bcd1", bcd_out, 12'h088);
      chk("sim_id1", done_id, 1'b1);

      // Fairness with both requests held high
      do_reset();
      req0 = 1'b1; bin0 = 7'd1;
      req1 = 1'b1; bin1 = 7'd2;
      repeat (7) tick();                         // t+7
      for (int k = 0; k < 4; k++) begin
         chk("fair_gap", done, 1'b0);
         tick();                                 // t+8+9k
         chk("fair_done", done, 1'b1);
         chk("fair_id", done_id, k % 2);
         chk("fair_bcd", bcd_out, (k % 2 == 0) ? 12'h001 : 12'h002);
         repeat (8) tick();
      end
      req0 = 1'b0;
      req1 = 1'b0;

      // Reset mid-operation abandons the conversion
      do_reset();
      req1 = 1'b1; bin1 = 7'd64;
      tick();                                    // t+1
      chk("mid_ack1", ack1, 1'b1);
      req1 = 1'b0;
      repeat (3) tick();                         // t+4
      rst = 1'b1;
      tick();                                    // t+5
      chk("mid_busy", busy, 1'b0);
      chk("mid_bcd", bcd_out, 12'h000);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("mid_no_done", {done, busy}, 2'b00);
         tick();
      end
      conv(1'b0, 7'd64, 12'h064);

      // Exhaustive sweep on requester 1
      for (int v = 0; v < 128; v++) begin
         gold = 12'((v / 100) << 8) | 12'(((v / 10) % 10) << 4) | 12'(v % 10);
         conv(1'b1, 7'(v), gold);
         chk("digits_le9", {bcd_out[11:8] <= 4'd9, bcd_out[7:4] <= 4'd9, bcd_out[3:0] <= 4'd9},
             3'b111);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
